// File: rtl/chip_top.sv
// UART-controlled GPIO block: 8N1 command parser with a small register map.
// Optional bidirectional GPIO port is enabled by defining CHIP_GPIO_IO_EN.
module chip_top #(
  parameter int UART_DIV    = 260,
  parameter int GPIO_IN_CH  = 4,
  parameter int GPIO_OUT_CH = 18,
  parameter int GPIO_IO_CH  = 16
) (
  input  logic                   clk_ref,
  input  logic                   reset_sw,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  input  logic [GPIO_IN_CH-1:0]  gpio_in,
  output logic [GPIO_OUT_CH-1:0] gpio_out,
  inout  wire  [GPIO_IO_CH-1:0]  gpio_io
);

  localparam int CW = $clog2(UART_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(UART_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(UART_DIV / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_D2    = 3'd2;
  localparam logic [2:0] S_D1    = 3'd3;
  localparam logic [2:0] S_D0    = 3'd4;
  localparam logic [2:0] S_REPLY = 3'd5;

  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] ACK    = 8'h4B;

  logic                  r_rx_m, r_rx_s, r_rx_d;
  logic [GPIO_IN_CH-1:0] r_gin_m, r_gin_s;

  logic       r_rx_busy, r_rx_valid;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0] r_rx_bit;
  logic [7:0] r_rx_sh, r_rx_data;

  logic [2:0]  r_state;
  logic        r_is_wr;
  logic [7:0]  r_addr, r_d2, r_d1;
  logic [23:0] r_reply;
  logic [1:0]  r_left;
  logic        r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic [9:0]  r_tx_frame;
  logic [GPIO_OUT_CH-1:0] r_gpio_out;

  logic        w_wr_en, w_tx_done;
  logic [23:0] w_wval, w_rdata;

`ifdef CHIP_GPIO_IO_EN
  logic [GPIO_IO_CH-1:0] r_io_m, r_io_s, r_io_data, r_io_dir;

  always_ff @(posedge clk_ref or negedge reset_sw) begin
    if (!reset_sw) begin
      r_io_m <= '0;
      r_io_s <= '0;
    end else begin
      r_io_m <= gpio_io;
      r_io_s <= r_io_m;
    end
  end

  for (genvar gi = 0; gi < GPIO_IO_CH; gi++) begin : g_io
    assign gpio_io[gi] = r_io_dir[gi] ? r_io_data[gi] : 1'bz;
  end
`else
  assign gpio_io = {GPIO_IO_CH{1'bz}};
`endif

  always_ff @(posedge clk_ref or negedge reset_sw) begin
    if (!reset_sw) begin
      r_rx_m  <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
      r_gin_m <= '0;
      r_gin_s <= '0;
    end else begin
      r_rx_m  <= uart_rx;
      r_rx_s  <= r_rx_m;
      r_rx_d  <= r_rx_s;
      r_gin_m <= gpio_in;
      r_gin_s <= r_gin_m;
    end
  end

  // Bit 0 is the start bit (checked at half period), 1..8 data, 9 stop.
  always_ff @(posedge clk_ref or negedge reset_sw) begin
    if (!reset_sw) begin
      r_rx_busy  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_d && !r_rx_s) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= '0;
        end
      end else if ((r_rx_bit == 4'd0 && r_rx_cnt == HALF) ||
                   (r_rx_bit != 4'd0 && r_rx_cnt == FULL)) begin
        r_rx_cnt <= '0;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s) r_rx_busy <= 1'b0;
          else        r_rx_bit  <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_sh;
          end
        end else begin
          r_rx_sh  <= {r_rx_s, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 4'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
    end
  end

  assign w_wr_en   = (r_state == S_D0) && r_rx_valid;
  assign w_wval    = {r_d2, r_d1, r_rx_data};
  assign w_tx_done = r_tx_busy && (r_tx_cnt == FULL) && (r_tx_bit == 4'd9);

  always_comb begin
    w_rdata = '0;
    case (r_rx_data)
      8'h00: w_rdata = 24'(r_gin_s);
      8'h01: w_rdata = 24'(r_gpio_out);
`ifdef CHIP_GPIO_IO_EN
      8'h02: w_rdata = 24'(r_io_s);
      8'h03: w_rdata = 24'(r_io_dir);
`endif
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_ref or negedge reset_sw) begin
    if (!reset_sw) begin
      r_gpio_out <= '0;
`ifdef CHIP_GPIO_IO_EN
      r_io_data  <= '0;
      r_io_dir   <= '0;
`endif
    end else if (w_wr_en) begin
      case (r_addr)
        8'h01: r_gpio_out <= GPIO_OUT_CH'(w_wval);
`ifdef CHIP_GPIO_IO_EN
        8'h02: r_io_data  <= GPIO_IO_CH'(w_wval);
        8'h03: r_io_dir   <= GPIO_IO_CH'(w_wval);
`endif
        default: ;
      endcase
    end
  end

  // Transmitter shares this block with the parser so the next reply byte can
  // be loaded on the same edge the previous stop bit completes.
  always_ff @(posedge clk_ref or negedge reset_sw) begin
    if (!reset_sw) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_d2       <= '0;
      r_d1       <= '0;
      r_reply    <= '0;
      r_left     <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_frame <= '1;
    end else begin
      if (r_tx_busy) begin
        if (r_tx_cnt == FULL) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 4'd9) begin
            r_tx_busy <= 1'b0;
          end else begin
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx_frame <= {1'b1, r_tx_frame[9:1]};
          end
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: if (r_rx_valid) begin
          if (r_rx_data == CMD_RD) begin
            r_is_wr <= 1'b0;
            r_state <= S_ADDR;
          end else if (r_rx_data == CMD_WR) begin
            r_is_wr <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: if (r_rx_valid) begin
          if (r_is_wr) begin
            r_addr  <= r_rx_data;
            r_state <= S_D2;
          end else begin
            r_reply <= w_rdata;
            r_left  <= 2'd3;
            r_state <= S_REPLY;
          end
        end
        S_D2: if (r_rx_valid) begin
          r_d2    <= r_rx_data;
          r_state <= S_D1;
        end
        S_D1: if (r_rx_valid) begin
          r_d1    <= r_rx_data;
          r_state <= S_D0;
        end
        S_D0: if (r_rx_valid) begin
          r_reply <= {ACK, 16'h0000};
          r_left  <= 2'd1;
          r_state <= S_REPLY;
        end
        S_REPLY: if (!r_tx_busy || w_tx_done) begin
          if (r_left != 2'd0) begin
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_frame <= {1'b1, r_reply[23:16], 1'b0};
            r_reply    <= {r_reply[15:0], 8'h00};
            r_left     <= r_left - 2'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx  = r_tx_frame[0];
  assign gpio_out = r_gpio_out;

endmodule

// File: tb/tb_chip_top.sv
// Bench for chip_top: vector table, directed corner sequences, randomized
// commands against a register-map model.
module tb_chip_top;

  localparam int DIV = 8;
  localparam int GI  = 4;
  localparam int GO  = 18;
  localparam int GIO = 16;

  logic           clk_ref  = 1'b0;
  logic           reset_sw = 1'b0;
  logic           uart_rx  = 1'b1;
  logic [GI-1:0]  gpio_in  = '0;
  wire            uart_tx;
  wire  [GO-1:0]  gpio_out;
  wire  [GIO-1:0] gpio_io;
  logic [GIO-1:0] ext_en  = '0;
  logic [GIO-1:0] ext_val = '0;

  for (genvar gi = 0; gi < GIO; gi++) begin : g_ext
    assign gpio_io[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  chip_top #(.UART_DIV(DIV), .GPIO_IN_CH(GI), .GPIO_OUT_CH(GO), .GPIO_IO_CH(GIO)) dut (
    .clk_ref(clk_ref), .reset_sw(reset_sw), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_io(gpio_io)
  );

  always #5 clk_ref = ~clk_ref;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_ref) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reply monitor: decodes uart_tx frames and records each start time.
  byte unsigned rxq[$];
  int           rxt[$];
  bit           mon_en = 1'b1;
  logic [7:0]   mon_b;
  int           mon_t;

  initial begin
    forever begin
      @(negedge clk_ref);
      if (mon_en && reset_sw && uart_tx === 1'b0) begin
        mon_t = cyc;
        repeat (DIV/2) @(negedge clk_ref);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk_ref);
          mon_b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk_ref);
        check("tx_stop_bit", {31'b0, uart_tx}, 32'd1);
        rxq.push_back(mon_b);
        rxt.push_back(mon_t);
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stopv, input int nbits);
    logic [9:0] f;
    f = {stopv, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rx = f[i];
      repeat (DIV) @(negedge clk_ref);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_cmd(input int nb, input logic [39:0] cmd);
    logic [39:0] c;
    for (int i = 0; i < nb; i++) begin
      c = cmd >> (8 * (nb - 1 - i));
      send_frame(c[7:0], 1'b1, 10);
    end
  endtask

  task automatic get_reply(input string nm, input int nexp, input logic [31:0] vexp);
    int k;
    logic [31:0] v;
    k = 0;
    while (rxq.size() < nexp && k < (nexp * 10 + 40) * DIV) begin
      @(negedge clk_ref);
      k++;
    end
    repeat (14 * DIV) @(negedge clk_ref);
    v = '0;
    foreach (rxq[i]) v = (v << 8) | 32'(rxq[i]);
    check({nm, "_count"}, rxq.size(), nexp);
    check({nm, "_data"}, v, vexp);
    for (int i = 1; i < rxt.size(); i++)
      check({nm, "_gap"}, rxt[i] - rxt[i-1], 10 * DIV);
    rxq.delete();
    rxt.delete();
  endtask

  task automatic wait_sync();
    repeat (4) @(negedge clk_ref);
  endtask

  typedef struct {
    int          nb;
    logic [39:0] cmd;
    logic [3:0]  gin;
    int          nrep;
    logic [31:0] rep;
    logic [17:0] gout;
  } vec_t;

  vec_t vt[10];

  // Register-map model for the randomized phase.
  logic [GO-1:0]  m_out;
  logic [GIO-1:0] m_dir, m_data;

  function automatic logic [23:0] m_pins();
    return 24'((m_dir & m_data) | (~m_dir & ext_val));
  endfunction

  function automatic logic [23:0] m_read(input int a);
    case (a)
      0: return 24'(gpio_in);
      1: return 24'(m_out);
`ifdef CHIP_GPIO_IO_EN
      2: return m_pins();
      3: return 24'(m_dir);
`endif
      default: return 24'h0;
    endcase
  endfunction

  task automatic m_write(input int a, input logic [23:0] v);
    case (a)
      1: m_out = v % (24'd1 << GO);
`ifdef CHIP_GPIO_IO_EN
      2: m_data = v[GIO-1:0];
      3: m_dir  = v[GIO-1:0];
`endif
      default: ;
    endcase
  endtask

  initial begin
    int          k;
    logic [31:0] r32;
    logic [23:0] rv;
    int          ra;
    bit          rw;

    vt[0] = '{5, 40'h570103FFFF, 4'hA, 1, 32'h4B,     18'h3FFFF};
    vt[1] = '{2, 40'h5200,       4'hA, 3, 32'h00000A, 18'h3FFFF};
    vt[2] = '{2, 40'h5201,       4'h3, 3, 32'h03FFFF, 18'h3FFFF};
    vt[3] = '{5, 40'h5701123456, 4'h3, 1, 32'h4B,     18'h23456};
    vt[4] = '{2, 40'h5201,       4'h3, 3, 32'h023456, 18'h23456};
    vt[5] = '{5, 40'h5705000001, 4'h3, 1, 32'h4B,     18'h23456};
    vt[6] = '{2, 40'h5205,       4'h3, 3, 32'h000000, 18'h23456};
    vt[7] = '{5, 40'h5700FFFFFF, 4'h5, 1, 32'h4B,     18'h23456};
    vt[8] = '{2, 40'h5200,       4'h5, 3, 32'h000005, 18'h23456};
`ifdef CHIP_GPIO_IO_EN
    vt[9] = '{2, 40'h5203,       4'h5, 3, 32'h000000, 18'h23456};
`else
    vt[9] = '{2, 40'h5202,       4'h5, 3, 32'h000000, 18'h23456};
`endif

    repeat (3) @(negedge clk_ref);
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_gpio_out", 32'(gpio_out), 32'd0);
    reset_sw = 1'b1;
    repeat (4) @(negedge clk_ref);

    for (int i = 0; i < 10; i++) begin
      gpio_in = vt[i].gin;
      wait_sync();
      send_cmd(vt[i].nb, vt[i].cmd);
      get_reply($sformatf("vec%0d", i), vt[i].nrep, vt[i].rep);
      check($sformatf("vec%0d_gpio_out", i), 32'(gpio_out), 32'(vt[i].gout));
    end

    // Bad stop bit is discarded; unknown command byte is ignored.
    gpio_in = 4'hA;
    wait_sync();
    send_frame(8'h57, 1'b0, 10);
    repeat (3 * DIV) @(negedge clk_ref);
    send_cmd(2, 40'h5200);
    get_reply("badstop_read", 3, 32'h00000A);
    send_cmd(1, 40'h33);
    get_reply("unknown_cmd", 0, 32'h0);
    send_cmd(2, 40'h5200);
    get_reply("after_unknown", 3, 32'h00000A);

    // Bytes arriving while replying are dropped.
    send_cmd(2, 40'h5200);
    send_cmd(2, 40'h5201);
    get_reply("reply_drop", 3, 32'h00000A);

`ifdef CHIP_GPIO_IO_EN
    send_cmd(5, 40'h57030000F0);
    get_reply("io_dir_wr", 1, 32'h4B);
    send_cmd(5, 40'h57020000A5);
    get_reply("io_data_wr", 1, 32'h4B);
    ext_val = 16'h000F;
    ext_en  = 16'hFF0F;
    wait_sync();
    check("io_pins", 32'(gpio_io), 32'h00AF);
    send_cmd(2, 40'h5202);
    get_reply("io_read", 3, 32'h0000AF);
    ext_en = '0;
    send_cmd(5, 40'h5703000000);
    get_reply("io_dir_clr", 1, 32'h4B);
`else
    send_cmd(5, 40'h570300FFFF);
    get_reply("noio_dir_wr", 1, 32'h4B);
    ext_en  = '1;
    ext_val = 16'h5A3C;
    wait_sync();
    check("noio_pins_a", 32'(gpio_io), 32'h5A3C);
    ext_val = 16'hA5C3;
    wait_sync();
    check("noio_pins_b", 32'(gpio_io), 32'hA5C3);
    send_cmd(2, 40'h5203);
    get_reply("noio_dir_rd", 3, 32'h000000);
    send_cmd(2, 40'h5202);
    get_reply("noio_data_rd", 3, 32'h000000);
    ext_en = '0;
`endif

    // Reset in the middle of a write command.
    send_cmd(5, 40'h5701123456);
    get_reply("pre_reset_wr", 1, 32'h4B);
    send_cmd(3, 40'h570100);
    send_frame(8'hFF, 1'b1, 4);
    @(negedge clk_ref);
    #1 reset_sw = 1'b0;
    #1;
    check("midcmd_rst_gpio_out", 32'(gpio_out), 32'd0);
    check("midcmd_rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    repeat (5) @(negedge clk_ref);
    reset_sw = 1'b1;
    repeat (2 * DIV) @(negedge clk_ref);
    send_cmd(2, 40'h5201);
    get_reply("post_reset_rd", 3, 32'h000000);
    check("post_reset_gpio_out", 32'(gpio_out), 32'd0);

    // Reset in the middle of a reply frame.
    mon_en = 1'b0;
    send_cmd(2, 40'h5200);
    k = 0;
    while (uart_tx !== 1'b0 && k < 20 * DIV) begin
      @(negedge clk_ref);
      k++;
    end
    check("midreply_started", {31'b0, uart_tx}, 32'd0);
    repeat (3 * DIV) @(negedge clk_ref);
    #1 reset_sw = 1'b0;
    #1;
    check("midreply_rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    repeat (3) @(negedge clk_ref);
    reset_sw = 1'b1;
    repeat (40 * DIV) @(negedge clk_ref);
    check("midreply_tx_quiet", {31'b0, uart_tx}, 32'd1);
    rxq.delete();
    rxt.delete();
    mon_en = 1'b1;
    send_cmd(2, 40'h5200);
    get_reply("first_after_rst", 3, 32'h00000A);

    // Randomized commands against the model, starting from reset.
    reset_sw = 1'b0;
    repeat (3) @(negedge clk_ref);
    reset_sw = 1'b1;
    m_out  = '0;
    m_dir  = '0;
    m_data = '0;
    repeat (4) @(negedge clk_ref);
    for (int it = 0; it < 30; it++) begin
      r32     = $urandom;
      gpio_in = r32[GI-1:0];
      r32     = $urandom;
      ext_val = r32[GIO-1:0];
      ext_en  = ~m_dir;
      wait_sync();
      check($sformatf("rnd%0d_pins", it), 32'(gpio_io), 32'(m_pins()));
      r32 = $urandom;
      rv  = r32[23:0];
      ra  = int'($urandom_range(0, 5));
      rw  = bit'($urandom_range(0, 1));
      if (rw) begin
        send_cmd(5, {8'h57, 8'(ra), rv});
        m_write(ra, rv);
        get_reply($sformatf("rnd%0d_wr", it), 1, 32'h4B);
      end else begin
        send_cmd(2, {24'h0, 8'h52, 8'(ra)});
        get_reply($sformatf("rnd%0d_rd", it), 3, 32'(m_read(ra)));
      end
      check($sformatf("rnd%0d_gpio_out", it), 32'(gpio_out), 32'(m_out));
    end
    ext_en = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chip_top.md
CHIP_TOP -- requirements
Module: chip_top

Interface
REQ-001 The clock SHALL be clk_ref and the reset SHALL be reset_sw; there is one clock, and reset is asynchronous and active-low.
REQ-002 Parameter UART_DIV, default 260, SHALL set the clk_ref cycles per UART bit (38400 baud at 10 MHz).
REQ-003 Parameter GPIO_IN_CH, default 4, SHALL set the gpio_in width.
REQ-004 Parameter GPIO_OUT_CH, default 18, SHALL set the gpio_out width.
REQ-005 Parameter GPIO_IO_CH, default 16, SHALL set the gpio_io width.
REQ-006 Port clk_ref SHALL be an input, 1 bit wide, the system clock.
REQ-007 Port reset_sw SHALL be an input, 1 bit wide, the async active-low reset.
REQ-008 Port uart_rx SHALL be an input, 1 bit wide, the serial command input (idle high).
REQ-009 Port uart_tx SHALL be an output, 1 bit wide, the serial reply output (idle high).
REQ-010 Port gpio_in SHALL be an input, GPIO_IN_CH bits wide, general-purpose inputs.
REQ-011 Port gpio_out SHALL be an output, GPIO_OUT_CH bits wide, general-purpose outputs.
REQ-012 Port gpio_io SHALL be an inout, GPIO_IO_CH bits wide, bidirectional pins, per-bit tristate.

Function
REQ-013 uart_rx, gpio_in and gpio_io SHALL each pass through a 2-flop synchronizer before use.
REQ-014 UART frames SHALL be 8N1, LSB first.
REQ-015 The receiver SHALL detect start on a synchronized falling edge, re-check low at UART_DIV/2, then sample each bit at mid-bit.
REQ-016 A frame whose stop bit samples 0 SHALL be discarded with no parser effect.
REQ-017 Register map: addr 0x00 GPIO_IN (read-only, zero-extended); 0x01 GPIO_OUT (RW); 0x02 IO_DATA (write = output latch, read = synchronized pin state); 0x03 IO_DIR (RW, 1 = drive); other addresses read 0 and ignore writes.
REQ-018 Write command: bytes 0x57, addr, d2, d1, d0; the 24-bit value {d2,d1,d0} SHALL be truncated to the register width (LSBs kept).
REQ-019 On a write, the register SHALL update on the cycle after d0 is accepted, then the block SHALL reply with one byte 0x4B.
REQ-020 Read command: bytes 0x52, addr; the block SHALL reply with three bytes d2, d1, d0 (MSB first, zero-extended), captured on the cycle the addr byte is accepted.
REQ-021 A first byte other than 0x52 or 0x57 SHALL be ignored, and the parser SHALL stay in IDLE.
REQ-022 Parser states SHALL be IDLE, ADDR, D2, D1, D0, REPLY; REPLY SHALL return to IDLE after the last stop bit is sent.
REQ-023 Bytes completed while in REPLY SHALL be dropped.
REQ-024 No inter-byte timeout SHALL exist; a partial command SHALL wait indefinitely.
REQ-025 Reply bytes SHALL be sent back-to-back, each a full 10-bit frame of UART_DIV cycles per bit.
REQ-026 gpio_io[i] SHALL be driven with IO_DATA[i] when IO_DIR[i]=1, else it SHALL be high-Z.
REQ-027 gpio_out SHALL be a direct register output.

Reset
REQ-028 When reset_sw=0, outputs SHALL go immediately to: gpio_out=0, IO_DATA=0, IO_DIR=0 (gpio_io all high-Z), uart_tx=1.
REQ-029 When reset_sw=0, the parser SHALL go to IDLE and the receiver/transmitter counters SHALL clear.
REQ-030 Reset asserted mid-frame or mid-command SHALL abort it with no register change.
REQ-031 After release, the first valid start bit SHALL be accepted.

Configuration
REQ-032 Macro CHIP_GPIO_IO_EN SHALL control the bidirectional GPIO; when defined, gpio_io, IO_DATA and IO_DIR SHALL behave as specified above.
REQ-033 When CHIP_GPIO_IO_EN is undefined, the gpio_io port SHALL remain but be permanently high-Z; addresses 0x02 and 0x03 SHALL read 0 and ignore writes, still acked with 0x4B.

Verification
REQ-034 Release reset, then send 57 01 03 FF FF -> gpio_out=18'h3FFFF, reply 4B.
REQ-035 gpio_in=4'hA, send 52 00 -> reply 00 00 0A.
REQ-036 Send 57 03 00 00 F0 then 57 02 00 00 A5 -> gpio_io[7:4]=4'hA, other bits Z; external drive 0x0F on [3:0] then send 52 02 -> reply 00 00 AF.
REQ-037 Frame with stop bit 0 before 52 00 -> the bad frame is ignored; the read still replies correctly; send 33 -> no reply.
REQ-038 Assert reset_sw after 57 01 00 -> gpio_out stays 0, uart_tx=1; a subsequent 52 01 -> reply 00 00 00.
REQ-039 Build without CHIP_GPIO_IO_EN, send 57 03 00 FF FF -> reply 4B, gpio_io all Z; 52 03 -> reply 00 00 00.
